// File: rtl/aes_enc_scheduler.sv
// rtl/aes_enc_scheduler.sv - two-requester round-robin sequencer for the AES encipher engine
// Grants one block at a time, starts the engine, waits for completion or watchdog timeout.
module aes_enc_scheduler #(
  parameter int TO_W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         key_ready,
  input  logic         req0_valid,
  input  logic [127:0] req0_block,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [127:0] req1_block,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_block,
  output logic         rsp_err,
  output logic         enc_next,
  output logic [127:0] enc_block,
  input  logic         enc_ready,
  input  logic [127:0] enc_result,
  output logic         busy,
  output logic         err_sticky,
  input  logic         err_clr
);

  localparam logic [TO_W-1:0] TIMEOUT = '1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state;
  logic             last_grant;
  logic             id_q;
  logic [TO_W-1:0]  cnt;
  logic [127:0]     blk_q;
  logic             can_grant;

  // Engine must be idle as well: after a timeout it may still be finishing the old job.
  assign can_grant  = (state == IDLE) && key_ready && enc_ready;
  assign req0_ready = can_grant && req0_valid && (!req1_valid || last_grant);
  assign req1_ready = can_grant && req1_valid && (!req0_valid || !last_grant);
  assign enc_block  = blk_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      id_q       <= 1'b0;
      cnt        <= '0;
      blk_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_block  <= '0;
      rsp_err    <= 1'b0;
      enc_next   <= 1'b0;
      busy       <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      enc_next <= 1'b0;
      if (err_clr) err_sticky <= 1'b0;
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            blk_q      <= req1_ready ? req1_block : req0_block;
            id_q       <= req1_ready;
            last_grant <= req1_ready;
            enc_next   <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != TIMEOUT) cnt <= cnt + 1'b1;
          // The engine only drops enc_ready a cycle after the start, so ignore it at cnt 0.
          if (cnt != '0 && enc_ready) begin
            rsp_block <= enc_result;
            rsp_err   <= 1'b0;
            rsp_id    <= id_q;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (cnt == TIMEOUT) begin
            rsp_block  <= '0;
            rsp_err    <= 1'b1;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            err_sticky <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_enc_scheduler.sv
// tb/tb_aes_enc_scheduler.sv - scoreboard bench for aes_enc_scheduler
// Stub engine with fixed 128-bit-key latency; negedge predictor/monitor checks grants and responses.
module tb_aes_enc_scheduler;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 0, reset_n = 0, key_ready = 1, err_clr = 0, rsp_ready = 1;
  logic req0_valid = 0, req1_valid = 0;
  logic [127:0] req0_block = '0, req1_block = '0;
  logic req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, enc_next, busy, err_sticky;
  logic [127:0] rsp_block, enc_block, enc_result;
  logic enc_ready;

  aes_enc_scheduler #(.TO_W(6)) dut (
    .clk(clk), .reset_n(reset_n), .key_ready(key_ready),
    .req0_valid(req0_valid), .req0_block(req0_block), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_block(req1_block), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_block(rsp_block),
    .rsp_err(rsp_err), .enc_next(enc_next), .enc_block(enc_block), .enc_ready(enc_ready),
    .enc_result(enc_result), .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Engine behaviour: known answer for the FIPS-197 vector, a fixed permutation otherwise.
  function automatic logic [127:0] ref_enc(input logic [127:0] p);
    if (p == FIPS_PT) return FIPS_CT;
    return {p[63:0], p[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // Stub engine: enc_ready drops after enc_next, returns 21 cycles later unless hung.
  logic stub_hang = 0;
  int   stub_cnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_ready  <= 1'b1;
      enc_result <= '0;
      stub_cnt   <= 0;
    end else if (enc_next) begin
      enc_ready <= 1'b0;
      stub_cnt  <= 21;
    end else if (!enc_ready) begin
      if (stub_cnt > 1) stub_cnt <= stub_cnt - 1;
      else if (!stub_hang) begin
        enc_ready  <= 1'b1;
        enc_result <= ref_enc(enc_block);
      end
    end
  end

  typedef struct {logic id; logic [127:0] blk; logic err;} exp_t;
  exp_t sb[$];
  logic grant_log[$];
  logic m_idle = 1, m_last = 1, job_active = 0, prev_valid = 0;
  int cycle = 0, acc_cycle = -10, exp_lat = 24, n_resp = 0;
  logic h_id, h_err;
  logic [127:0] h_blk;

  always @(negedge clk) begin
    logic e0, e1, gid;
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      m_idle = 1; m_last = 1; job_active = 0; prev_valid = 0;
    end else begin
      cycle++;
      check("busy", busy, !m_idle);
      check("enc_next", enc_next, job_active && (cycle == acc_cycle + 1));
      e0 = 0; e1 = 0;
      if (m_idle && key_ready && enc_ready) begin
        if (req0_valid && req1_valid) begin
          e0 = m_last; e1 = !m_last;
        end else begin
          e0 = req0_valid; e1 = req1_valid;
        end
      end
      check("req0_ready", req0_ready, e0);
      check("req1_ready", req1_ready, e1);
      if (e0 || e1) begin
        gid = e1;
        sb.push_back('{gid, stub_hang ? 128'h0 : ref_enc(gid ? req1_block : req0_block), stub_hang});
        grant_log.push_back(gid);
        m_last = gid; m_idle = 0; job_active = 1; acc_cycle = cycle;
        exp_lat = stub_hang ? 66 : 24;
      end
      if (rsp_valid && !prev_valid) begin
        check("rsp_latency", 128'(cycle - acc_cycle), 128'(exp_lat));
        h_id = rsp_id; h_blk = rsp_block; h_err = rsp_err;
      end else if (rsp_valid) begin
        check("rsp_stable", {rsp_id, rsp_err, rsp_block}, {h_id, h_err, h_blk});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_block", rsp_block, e.blk);
          check("rsp_err", rsp_err, e.err);
        end
        m_idle = 1; job_active = 0; n_resp++;
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_resp(input int n, input int budget);
    int target = n_resp + n;
    int k = 0;
    while (n_resp < target && k < budget) begin tick(); k++; end
    check("wait_resp_timeout", n_resp >= target, 1);
  endtask

  task automatic drain();
    int k = 0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    while (!(m_idle && sb.size() == 0) && k < 300) begin tick(); k++; end
    check("drain_timeout", m_idle && sb.size() == 0, 1);
  endtask

  initial begin
    int gl, k;
    repeat (3) tick();
    reset_n = 1;
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_enc_block", enc_block, 0);

    // Contention from reset: strict alternation starting with requester 0.
    req0_block = 128'h1; req1_block = 128'h2;
    req0_valid = 1; req1_valid = 1;
    wait_resp(4, 200);
    check("grant0", grant_log[0], 0);
    check("grant1", grant_log[1], 1);
    check("grant2", grant_log[2], 0);
    check("grant3", grant_log[3], 1);
    drain();

    // FIPS-197 known answer through requester 0.
    req0_block = FIPS_PT; req0_valid = 1;
    tick(); req0_valid = 0;
    wait_resp(1, 100);
    drain();

    // Backpressure: response held, no new grant until consumed.
    req0_block = 128'hdead_beef; req0_valid = 1; rsp_ready = 0;
    k = 0;
    while (!rsp_valid && k < 100) begin tick(); k++; end
    check("bp_rsp_valid", rsp_valid, 1);
    repeat (10) tick();
    rsp_ready = 1;
    tick(); tick();
    req0_valid = 0;
    drain();

    // Key gating.
    key_ready = 0; req1_block = 128'h1234; req1_valid = 1;
    repeat (20) begin
      tick();
      check("keygate_busy", busy, 0);
      check("keygate_ready", req1_ready, 0);
    end
    key_ready = 1; #1;
    check("keygate_release", req1_ready, 1);
    tick(); req1_valid = 0;
    drain();

    // Watchdog with a hung engine.
    stub_hang = 1; req0_block = 128'h77; req0_valid = 1;
    wait_resp(1, 120);
    check("wd_err_sticky", err_sticky, 1);
    repeat (10) tick();
    err_clr = 1; tick(); err_clr = 0;
    check("wd_err_clr", err_sticky, 0);
    req0_valid = 0; stub_hang = 0;
    repeat (5) tick();
    drain();

    // Reset in the middle of a job.
    req0_block = 128'h99; req0_valid = 1;
    k = 0;
    while (!busy && k < 20) begin tick(); k++; end
    req0_valid = 0;
    repeat (5) tick();
    reset_n = 0; #1;
    check("rst_outputs", {rsp_valid, rsp_id, rsp_err, enc_next, busy, err_sticky, req0_ready, req1_ready}, 0);
    check("rst_rsp_block", rsp_block, 0);
    check("rst_enc_block", enc_block, 0);
    tick(); tick();
    reset_n = 1;
    gl = grant_log.size();
    req0_valid = 1; req1_valid = 1;
    wait_resp(2, 200);
    check("rst_grant_first", grant_log[gl], 0);
    check("rst_grant_second", grant_log[gl + 1], 1);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      tick();
      key_ready  = ($urandom_range(0, 9) < 8);
      rsp_ready  = ($urandom_range(0, 9) < 7);
      req0_valid = $urandom_range(0, 1);
      req1_valid = $urandom_range(0, 1);
      req0_block = {$urandom, $urandom, $urandom, $urandom};
      req1_block = {$urandom, $urandom, $urandom, $urandom};
    end
    key_ready = 1;
    drain();
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
